// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage: address and
// write-source selector encodings, the wide-access sequencer states and the
// MEM/WB register layout.
package mem_stage_pkg;

  // Data memory word-address width (4K x 16 words).
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // Where the data-memory address comes from.
  typedef enum logic [1:0] {
    ADDR_ALU     = 2'b00,
    ADDR_RD2     = 2'b01,
    ADDR_STACK   = 2'b10,
    ADDR_ALU_ALT = 2'b11
  } addr_sel_e;

  // What gets written to memory; the two PC sources are 32 bits wide.
  typedef enum logic [1:0] {
    WSRC_RD1         = 2'b00,
    WSRC_RD2         = 2'b01,
    WSRC_PC_PLUS_ONE = 2'b10,
    WSRC_PC          = 2'b11
  } wsrc_sel_e;

  // Wide (32-bit PC) accesses take two memory cycles.
  typedef enum logic {
    IDLE  = 1'b0,
    WORD2 = 1'b1
  } fsm_state_e;

  // Everything write-back needs, registered at the end of the stage.
  typedef struct packed {
    logic [15:0] mem_data;
    logic [15:0] alu_result;
    logic [15:0] ldm_value;
    logic [15:0] in_port_value;
    logic        reg_write;
    logic        outport_enable;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic        pc_load;
    logic [31:0] new_pc;
  } mem_wb_t;

  // A push of a PC source or a PC-restoring pop needs two 16-bit accesses.
  // A simultaneous push and pop is a push; the pop half is ignored.
  function automatic logic is_wide_op(input logic       push,
                                      input logic       pop,
                                      input logic       pc_choose_memory,
                                      input logic [1:0] wsrc);
    return (push && wsrc[1]) || (pop && !push && pc_choose_memory);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled so the
// upstream pipeline (master) and the stage (slave) share one port.
interface memory_stage_if #(
  parameter int ADDR_WIDTH = 12
);

  // EX/MEM register contents
  logic [15:0]           alu_result;
  logic [15:0]           read_data1;
  logic [15:0]           read_data2;
  logic [31:0]           pc;
  logic [31:0]           pc_plus_one;
  logic [15:0]           ldm_value;
  logic [15:0]           in_port_value;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_push;
  logic                  mem_pop;
  logic [1:0]            memory_address_select;
  logic [1:0]            memory_write_src_select;
  logic                  pc_choose_memory;
  logic                  reg_write;
  logic                  outport_enable;
  logic [1:0]            wb_sel;
  logic [2:0]            reg_write_address;

  // Stage responses
  logic                  stall;
  logic [15:0]           mem_data_out;
  logic [15:0]           alu_result_out;
  logic [15:0]           ldm_value_out;
  logic [15:0]           in_port_value_out;
  logic                  reg_write_out;
  logic                  outport_enable_out;
  logic [1:0]            wb_sel_out;
  logic [2:0]            reg_write_address_out;
  logic [31:0]           new_pc_out;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] sp_out;

  modport master (
    output alu_result, read_data1, read_data2, pc, pc_plus_one,
           ldm_value, in_port_value, mem_read, mem_write, mem_push, mem_pop,
           memory_address_select, memory_write_src_select, pc_choose_memory,
           reg_write, outport_enable, wb_sel, reg_write_address,
    input  stall, mem_data_out, alu_result_out, ldm_value_out,
           in_port_value_out, reg_write_out, outport_enable_out, wb_sel_out,
           reg_write_address_out, new_pc_out, pc_load, sp_out
  );

  modport slave (
    input  alu_result, read_data1, read_data2, pc, pc_plus_one,
           ldm_value, in_port_value, mem_read, mem_write, mem_push, mem_pop,
           memory_address_select, memory_write_src_select, pc_choose_memory,
           reg_write, outport_enable, wb_sel, reg_write_address,
    output stall, mem_data_out, alu_result_out, ldm_value_out,
           in_port_value_out, reg_write_out, outport_enable_out, wb_sel_out,
           reg_write_address_out, new_pc_out, pc_load, sp_out
  );

endinterface

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, combinational read of the
// same address, so a read-during-write returns the old contents.
module data_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  // NOTE: storage has no reset; contents survive a pipeline reset and a
  // reset branch would block mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory loads/stores, stack push/pop through an
// internal stack pointer, two-cycle sequencing of 32-bit PC push/pop, and the
// MEM/WB register feeding write-back.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = '1
) (
  input  logic          clk,
  input  logic          reset,
  memory_stage_if.slave bus
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  fsm_state_e  state_q, state_d;
  addr_t       sp_q, sp_d;
  logic [15:0] pop_low_q, pop_low_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  addr_sel_e   addr_sel;
  wsrc_sel_e   wsrc_sel;
  logic        push_op;
  logic        pop_op;
  logic        wide_op;
  logic        in_word2;
  logic        stall;
  addr_t       stack_addr;
  addr_t       mem_addr;
  logic [31:0] src_wide;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_we;

  assign addr_sel = addr_sel_e'(bus.memory_address_select);
  assign wsrc_sel = wsrc_sel_e'(bus.memory_write_src_select);
  assign push_op  = bus.mem_push;
  assign pop_op   = bus.mem_pop && !bus.mem_push;
  assign wide_op  = is_wide_op(bus.mem_push, bus.mem_pop, bus.pc_choose_memory,
                               bus.memory_write_src_select);
  assign in_word2 = (state_q == WORD2);

  // Hold upstream for the first word of a wide access; never while in reset.
  assign stall = (state_q == IDLE) && wide_op && reset;

  // Memory address: stack slot depends on push/pop direction and on which
  // word of a wide access is in flight.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    stack_addr = push_op ? sp_q : sp_q + addr_t'(1);
    if (in_word2) begin
      stack_addr = push_op ? sp_q - addr_t'(1) : sp_q + addr_t'(2);
    end
    unique case (addr_sel)
      ADDR_RD2:   mem_addr = bus.read_data2[ADDR_WIDTH-1:0];
      ADDR_STACK: mem_addr = stack_addr;
      default:    mem_addr = bus.alu_result[ADDR_WIDTH-1:0];
    endcase
  end

  // Write data: a wide push stores the high half first, then the low half.
  always_comb begin
    unique case (wsrc_sel)
      WSRC_RD1:         src_wide = {16'h0000, bus.read_data1};
      WSRC_RD2:         src_wide = {16'h0000, bus.read_data2};
      WSRC_PC_PLUS_ONE: src_wide = bus.pc_plus_one;
      default:          src_wide = bus.pc;
    endcase
    mem_wdata = src_wide[15:0];
    if (wide_op && push_op && !in_word2) begin
      mem_wdata = src_wide[31:16];
    end
  end

  assign mem_we = bus.mem_write || push_op;

  data_memory #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(16)
  ) u_data_memory (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Wide-access sequencer and stack-pointer next state.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    pop_low_d = pop_low_q;
    unique case (state_q)
      IDLE: begin
        if (wide_op) begin
          state_d   = WORD2;
          pop_low_d = mem_rdata;
        end else if (push_op) begin
          sp_d = sp_q - addr_t'(1);
        end else if (pop_op) begin
          sp_d = sp_q + addr_t'(1);
        end
      end
      WORD2: begin
        state_d = IDLE;
        if (push_op) begin
          sp_d = sp_q - addr_t'(2);
        end else if (pop_op) begin
          sp_d = sp_q + addr_t'(2);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB next state; the stall cycle becomes a write-back bubble.
  always_comb begin
    mem_wb_d                   = mem_wb_q;
    mem_wb_d.mem_data          = mem_rdata;
    mem_wb_d.alu_result        = bus.alu_result;
    mem_wb_d.ldm_value         = bus.ldm_value;
    mem_wb_d.in_port_value     = bus.in_port_value;
    mem_wb_d.wb_sel            = bus.wb_sel;
    mem_wb_d.reg_write_address = bus.reg_write_address;
    mem_wb_d.reg_write         = bus.reg_write && !stall;
    mem_wb_d.outport_enable    = bus.outport_enable && !stall;
    mem_wb_d.pc_load           = in_word2 && pop_op;
    if (in_word2 && pop_op) begin
      mem_wb_d.new_pc = {mem_rdata, pop_low_q};
    end
  end

  // Sequencer state, stack pointer and captured low half of a PC pop.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sp_q      <= SP_RESET;
      pop_low_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      pop_low_q <= pop_low_d;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.stall                 = stall;
  assign bus.mem_data_out          = mem_wb_q.mem_data;
  assign bus.alu_result_out        = mem_wb_q.alu_result;
  assign bus.ldm_value_out         = mem_wb_q.ldm_value;
  assign bus.in_port_value_out     = mem_wb_q.in_port_value;
  assign bus.reg_write_out         = mem_wb_q.reg_write;
  assign bus.outport_enable_out    = mem_wb_q.outport_enable;
  assign bus.wb_sel_out            = mem_wb_q.wb_sel;
  assign bus.reg_write_address_out = mem_wb_q.reg_write_address;
  assign bus.new_pc_out            = mem_wb_q.new_pc;
  assign bus.pc_load               = mem_wb_q.pc_load;
  assign bus.sp_out                = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the stimulus process runs an
// instruction-level model (memory array + stack pointer) and queues the
// expected MEM/WB contents per cycle; a monitor pops and compares after
// every rising edge.
module tb_memory_stage;
  import mem_stage_pkg::*;

  localparam int AW = DEFAULT_ADDR_WIDTH;
  typedef logic [AW-1:0] addr_t;

  typedef struct packed {
    logic [15:0] alu, rd1, rd2, ldm, inp;
    logic [31:0] pc, ppo;
    logic        rd, wr, push, pop, pcm, rw, oe;
    logic [1:0]  asel, wsrc, wbs;
    logic [2:0]  wa;
  } instr_t;

  typedef struct packed {
    logic [15:0] mem_data;
    logic        mem_known;
    logic [15:0] alu, ldm, inp;
    logic        rw, oe;
    logic [1:0]  wbs;
    logic [2:0]  wa;
    logic        pc_load;
    logic [31:0] new_pc;
    addr_t       sp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [15:0] mdl_mem   [1 << AW];
  bit          mdl_known [1 << AW];
  addr_t       m_sp;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  memory_stage_if #(.ADDR_WIDTH(AW)) bus  ();
  memory_stage_if #(.ADDR_WIDTH(AW)) bus0 ();

  memory_stage #(.ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  memory_stage #(.ADDR_WIDTH(AW), .SP_RESET(addr_t'(0))) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input instr_t in);
    bus.alu_result              = in.alu;
    bus.read_data1              = in.rd1;
    bus.read_data2              = in.rd2;
    bus.pc                      = in.pc;
    bus.pc_plus_one             = in.ppo;
    bus.ldm_value               = in.ldm;
    bus.in_port_value           = in.inp;
    bus.mem_read                = in.rd;
    bus.mem_write               = in.wr;
    bus.mem_push                = in.push;
    bus.mem_pop                 = in.pop;
    bus.memory_address_select   = in.asel;
    bus.memory_write_src_select = in.wsrc;
    bus.pc_choose_memory        = in.pcm;
    bus.reg_write               = in.rw;
    bus.outport_enable          = in.oe;
    bus.wb_sel                  = in.wbs;
    bus.reg_write_address       = in.wa;
  endtask

  task automatic drive_wrap(input logic push, input logic pop, input logic [15:0] data);
    bus0.alu_result              = 16'h0;
    bus0.read_data1              = data;
    bus0.read_data2              = 16'h0;
    bus0.pc                      = 32'h0;
    bus0.pc_plus_one             = 32'h0;
    bus0.ldm_value               = 16'h0;
    bus0.in_port_value           = 16'h0;
    bus0.mem_read                = 1'b0;
    bus0.mem_write               = 1'b0;
    bus0.mem_push                = push;
    bus0.mem_pop                 = pop;
    bus0.memory_address_select   = 2'b10;
    bus0.memory_write_src_select = 2'b00;
    bus0.pc_choose_memory        = 1'b0;
    bus0.reg_write               = 1'b0;
    bus0.outport_enable          = 1'b0;
    bus0.wb_sel                  = 2'b00;
    bus0.reg_write_address       = 3'd0;
  endtask

  function automatic logic [31:0] src_of(input instr_t in);
    case (in.wsrc)
      2'd0:    return {16'h0, in.rd1};
      2'd1:    return {16'h0, in.rd2};
      2'd2:    return in.ppo;
      default: return in.pc;
    endcase
  endfunction

  function automatic exp_t base_exp(input instr_t in, input logic bubble);
    exp_t e;
    e           = '0;
    e.alu       = in.alu;
    e.ldm       = in.ldm;
    e.inp       = in.inp;
    e.wbs       = in.wbs;
    e.wa        = in.wa;
    e.rw        = bubble ? 1'b0 : in.rw;
    e.oe        = bubble ? 1'b0 : in.oe;
    e.new_pc    = m_pc;
    e.pc_load   = 1'b0;
    return e;
  endfunction

  task automatic wr_mem(input addr_t a, input logic [15:0] d);
    mdl_mem[a]   = d;
    mdl_known[a] = 1'b1;
  endtask

  // Present one instruction for as many cycles as it occupies the stage.
  // Entered and left just after a falling edge.
  task automatic issue(input instr_t in);
    bit          wide;
    addr_t       a;
    logic [31:0] src;
    logic [15:0] lo, hi;
    exp_t        e;
    drive(in);
    src  = src_of(in);
    wide = (in.push && in.wsrc[1]) || (in.pop && !in.push && in.pcm);
    #1 check("stall", bus.stall, 32'(wide));
    if (!wide) begin
      case (in.asel)
        2'd1:    a = in.rd2[AW-1:0];
        2'd2:    a = in.push ? m_sp : addr_t'(m_sp + 1'b1);
        default: a = in.alu[AW-1:0];
      endcase
      e           = base_exp(in, 1'b0);
      e.mem_data  = mdl_mem[a];
      e.mem_known = mdl_known[a];
      if (in.wr || in.push) wr_mem(a, src[15:0]);
      if (in.push)     m_sp = m_sp - 1'b1;
      else if (in.pop) m_sp = m_sp + 1'b1;
      e.sp = m_sp;
      exp_q.push_back(e);
    end else if (in.push) begin
      a           = m_sp;
      e           = base_exp(in, 1'b1);
      e.mem_data  = mdl_mem[a];
      e.mem_known = mdl_known[a];
      wr_mem(a, src[31:16]);
      e.sp        = m_sp;
      exp_q.push_back(e);
      @(negedge clk);
      #1 check("stall_word2", bus.stall, 32'd0);
      a           = m_sp - 1'b1;
      e           = base_exp(in, 1'b0);
      e.mem_data  = mdl_mem[a];
      e.mem_known = mdl_known[a];
      wr_mem(a, src[15:0]);
      m_sp        = m_sp - 2'd2;
      e.sp        = m_sp;
      exp_q.push_back(e);
    end else begin
      a           = m_sp + 1'b1;
      lo          = mdl_mem[a];
      e           = base_exp(in, 1'b1);
      e.mem_data  = lo;
      e.mem_known = mdl_known[a];
      e.sp        = m_sp;
      exp_q.push_back(e);
      @(negedge clk);
      #1 check("stall_word2", bus.stall, 32'd0);
      a           = m_sp + 2'd2;
      hi          = mdl_mem[a];
      m_sp        = m_sp + 2'd2;
      m_pc        = {hi, lo};
      e           = base_exp(in, 1'b0);
      e.mem_data  = hi;
      e.mem_known = mdl_known[a];
      e.pc_load   = 1'b1;
      e.new_pc    = m_pc;
      e.sp        = m_sp;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic instr_t rand_instr(input int kind);
    instr_t in;
    int     v;
    in      = '0;
    in.alu  = {4'($urandom), 12'($urandom_range(0, 31))};
    in.rd1  = 16'($urandom);
    in.rd2  = {4'($urandom), 12'($urandom_range(0, 31))};
    in.ldm  = 16'($urandom);
    in.inp  = 16'($urandom);
    in.pc   = $urandom;
    in.ppo  = $urandom;
    in.rw   = 1'($urandom);
    in.oe   = 1'($urandom);
    in.wbs  = 2'($urandom);
    in.wa   = 3'($urandom);
    v       = $urandom_range(0, 2);
    in.asel = (v == 2) ? 2'd3 : 2'(v);
    in.wsrc = 2'($urandom_range(0, 1));
    case (kind)
      1: in.wr = 1'b1;
      2: in.rd = 1'b1;
      3: begin in.wr = 1'b1; in.rd = 1'b1; end
      4: begin in.push = 1'b1; in.asel = 2'd2; end
      5: begin in.pop = 1'b1; in.asel = 2'd2; end
      6: begin in.push = 1'b1; in.asel = 2'd2; in.wsrc = 2'($urandom_range(2, 3)); end
      7: begin in.pop = 1'b1; in.asel = 2'd2; in.pcm = 1'b1; end
      8: begin in.push = 1'b1; in.pop = 1'b1; in.asel = 2'd2; in.pcm = 1'($urandom); end
      default: ;
    endcase
    return in;
  endfunction

  // Monitor: one queued expectation per cycle, compared after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.mem_known) check("mem_data_out", bus.mem_data_out, e.mem_data);
        check("alu_result_out", bus.alu_result_out, e.alu);
        check("ldm_inport_out", {bus.ldm_value_out, bus.in_port_value_out}, {e.ldm, e.inp});
        check("wb_ctrl_out", {bus.outport_enable_out, bus.wb_sel_out, bus.reg_write_address_out},
              {e.oe, e.wbs, e.wa});
        check("reg_write_out", bus.reg_write_out, e.rw);
        check("pc_load", bus.pc_load, e.pc_load);
        check("new_pc_out", bus.new_pc_out, e.new_pc);
        check("sp_out", bus.sp_out, e.sp);
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    instr_t in;
    int     kind;
    addr_t  a1, a2;

    reset = 1'b0;
    drive('0);
    drive_wrap(1'b0, 1'b0, 16'h0);
    m_sp = '1;
    m_pc = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_sp", bus.sp_out, 32'hFFF);
    check("rst_stall", bus.stall, 32'd0);
    check("rst_mem_data", bus.mem_data_out, 32'd0);
    check("rst_reg_write", bus.reg_write_out, 32'd0);
    check("rst_pc_load", bus.pc_load, 32'd0);
    check("rst_new_pc", bus.new_pc_out, 32'd0);
    check("rst_sp_wrap_inst", bus0.sp_out, 32'd0);
    reset = 1'b1;

    // SP wrap on the instance whose stack pointer resets to 0
    drive_wrap(1'b1, 1'b0, 16'h7777);
    @(posedge clk); #2;
    check("wrap_push_sp", bus0.sp_out, 32'hFFF);
    @(negedge clk);
    drive_wrap(1'b0, 1'b1, 16'h0);
    @(posedge clk); #2;
    check("wrap_pop_sp", bus0.sp_out, 32'h000);
    check("wrap_pop_data", bus0.mem_data_out, 32'h7777);
    @(negedge clk);
    drive_wrap(1'b0, 1'b0, 16'h0);

    // Store then load
    in = '0; in.wr = 1'b1; in.alu = 16'h0010; in.rd1 = 16'hBEEF; issue(in);
    in = '0; in.rd = 1'b1; in.alu = 16'h0010; issue(in);
    // Single push / pop
    in = '0; in.push = 1'b1; in.asel = 2'd2; in.rd1 = 16'h1234; issue(in);
    in = '0; in.pop = 1'b1; in.asel = 2'd2; issue(in);
    // Wide push / pop of a PC
    in = '0; in.push = 1'b1; in.asel = 2'd2; in.wsrc = 2'd2; in.ppo = 32'h0001_0020; issue(in);
    in = '0; in.pop = 1'b1; in.asel = 2'd2; in.pcm = 1'b1; issue(in);
    in = '0; issue(in);
    // Push and pop together: push only
    in = '0; in.push = 1'b1; in.pop = 1'b1; in.pcm = 1'b1; in.asel = 2'd2; in.rd1 = 16'h5A5A;
    issue(in);
    in = '0; in.pop = 1'b1; in.asel = 2'd2; issue(in);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 8);
      in   = rand_instr(kind);
      a1   = m_sp + 1'b1;
      a2   = m_sp + 2'd2;
      if (kind == 7 && !(mdl_known[a1] && mdl_known[a2])) in.pcm = 1'b0;
      issue(in);
    end
    in = '0; issue(in);

    // Reset in the second cycle of a wide push
    reset = 1'b0;
    m_sp  = '1;
    m_pc  = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    in = '0; in.wr = 1'b1; in.alu = 16'h0FFE; in.rd1 = 16'hCAFE; issue(in);
    in = '0; in.push = 1'b1; in.asel = 2'd2; in.wsrc = 2'd2; in.ppo = 32'hABCD_1357;
    drive(in);
    #1 check("w2rst_stall_first", bus.stall, 32'd1);
    wr_mem(m_sp, 16'hABCD);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("w2rst_stall", bus.stall, 32'd0);
    check("w2rst_sp", bus.sp_out, 32'hFFF);
    check("w2rst_pc_load", bus.pc_load, 32'd0);
    @(negedge clk);
    check("w2rst_stall_held", bus.stall, 32'd0);
    check("w2rst_sp_held", bus.sp_out, 32'hFFF);
    drive('0);
    reset = 1'b1;
    in = '0; in.rd = 1'b1; in.alu = 16'h0FFF; issue(in);
    in = '0; in.rd = 1'b1; in.alu = 16'h0FFE; issue(in);
    in = '0; issue(in);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
